// File: rtl/mem_stage_ctrl.sv
// MEM-stage sequencer for one core: issues the data-memory request for the
// instruction in MEM, captures load data / SC result, owns the LR/SC
// reservation (with snoop invalidation), latches halt, and generates the
// global pipeline advance enable.
module mem_stage_ctrl #(
  parameter int GRAN_BITS = 2,
  parameter int ADDR_W    = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic [ADDR_W-1:0] dmemload,
  input  logic              MemRead_MEM,
  input  logic              MemWr_MEM,
  input  logic              datomic_MEM,
  input  logic [ADDR_W-1:0] alu_out_MEM,
  input  logic              is_halt_MEM,
  input  logic              snoop_inv,
  input  logic [ADDR_W-1:0] snoop_addr,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [ADDR_W-1:0] dmemaddr,
  output logic [ADDR_W-1:0] dmem_out_reg,
  output logic              pipeline_ctrl,
  output logic              halt
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, HALTED} state_t;

  state_t            state, next_state;
  logic              i_done;
  logic              i_ok;
  logic              mem_op, sc, lr;
  logic              resv_valid;
  logic [ADDR_W-1:0] resv_addr;
  logic              match_mem, match_snoop;

  assign i_ok   = ihit | i_done;
  assign mem_op = MemRead_MEM | MemWr_MEM;
  assign sc     = datomic_MEM & MemWr_MEM;
  assign lr     = datomic_MEM & MemRead_MEM;

  // Reservation matching ignores the sub-word address bits.
  assign match_mem   = resv_valid &
                       (alu_out_MEM[ADDR_W-1:GRAN_BITS] == resv_addr[ADDR_W-1:GRAN_BITS]);
  assign match_snoop = resv_valid &
                       (snoop_addr[ADDR_W-1:GRAN_BITS] == resv_addr[ADDR_W-1:GRAN_BITS]);

  assign dmemaddr = alu_out_MEM;
  assign halt     = (state == HALTED);

  // Next-state, request and advance-enable decode.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a signal unassigned and infer a latch.
    next_state    = state;
    pipeline_ctrl = 1'b0;
    dmemREN       = 1'b0;
    dmemWEN       = 1'b0;
    case (state)
      IDLE: begin
        if (!mem_op) begin
          pipeline_ctrl = i_ok;
          if (i_ok && is_halt_MEM) next_state = HALTED;
        end else if (sc && !match_mem) begin
          // Failing SC never reaches the bus.
          next_state = DONE;
        end else begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        dmemREN = MemRead_MEM;
        dmemWEN = MemWr_MEM;
        if (dhit) next_state = DONE;
      end
      DONE: begin
        pipeline_ctrl = i_ok;
        if (i_ok) next_state = is_halt_MEM ? HALTED : IDLE;
      end
      HALTED: ;
      default: next_state = IDLE;
    endcase
  end

  // State register and sticky instruction-fetch-complete flag.
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      state  <= IDLE;
      i_done <= 1'b0;
    end else begin
      state <= next_state;
      if (pipeline_ctrl) i_done <= 1'b0;
      else if (ihit)     i_done <= 1'b1;
    end
  end

  // Load/SC result capture and LR/SC reservation; later writes win, so an
  // LR completing in the same cycle as a matching snoop keeps its reservation.
  always_ff @(posedge CLK) begin
    if (RST) begin
      resv_valid   <= 1'b0;
      resv_addr    <= '0;
      dmem_out_reg <= '0;
    end else begin
      if (snoop_inv && match_snoop) resv_valid <= 1'b0;
      if (state == IDLE && sc && !match_mem) begin
        dmem_out_reg <= ADDR_W'(1);
        resv_valid   <= 1'b0;
      end
      if (state == ACCESS && dhit) begin
        if (MemRead_MEM) dmem_out_reg <= dmemload;
        if (sc) begin
          // SC success was decided at issue; a snoop during ACCESS does not undo it.
          dmem_out_reg <= '0;
          resv_valid   <= 1'b0;
        end
        if (lr) begin
          resv_valid <= 1'b1;
          resv_addr  <= alu_out_MEM;
        end
        if (MemWr_MEM && !datomic_MEM && match_mem) resv_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed scenarios followed by
// randomized instruction streams, checked against a transaction-level model.
module tb_mem_stage_ctrl;

  logic        CLK = 1'b0;
  logic        RST, ihit, dhit, MemRead_MEM, MemWr_MEM, datomic_MEM;
  logic        is_halt_MEM, snoop_inv;
  logic [31:0] dmemload, alu_out_MEM, snoop_addr;
  logic        dmemREN, dmemWEN, pipeline_ctrl, halt;
  logic [31:0] dmemaddr, dmem_out_reg;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: reservation and last result, updated per transaction.
  bit          m_rv  = 0;
  logic [31:0] m_ra  = '0;
  logic [31:0] m_res = '0;

  mem_stage_ctrl #(.GRAN_BITS(2), .ADDR_W(32)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .dmemload(dmemload),
    .MemRead_MEM(MemRead_MEM), .MemWr_MEM(MemWr_MEM), .datomic_MEM(datomic_MEM),
    .alu_out_MEM(alu_out_MEM), .is_halt_MEM(is_halt_MEM),
    .snoop_inv(snoop_inv), .snoop_addr(snoop_addr),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr),
    .dmem_out_reg(dmem_out_reg), .pipeline_ctrl(pipeline_ctrl), .halt(halt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    ihit = 0; dhit = 0; dmemload = '0; MemRead_MEM = 0; MemWr_MEM = 0;
    datomic_MEM = 0; alu_out_MEM = '0; is_halt_MEM = 0; snoop_inv = 0; snoop_addr = '0;
  endtask

  function automatic bit m_match(input logic [31:0] a);
    return m_rv && (a[31:2] == m_ra[31:2]);
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    idle_inputs();
    RST = 1;
    @(negedge CLK);
    RST = 0;
    m_rv = 0; m_ra = '0; m_res = '0;
    #1;
    check("rst_ren", dmemREN, 0);
    check("rst_wen", dmemWEN, 0);
    check("rst_addr", dmemaddr, 0);
    check("rst_out", dmem_out_reg, 0);
    check("rst_pc", pipeline_ctrl, 0);
    check("rst_halt", halt, 0);
  endtask

  // Non-memory instruction in MEM; advances once the fetch has completed.
  task automatic do_alu(input int ihit_at, input bit hlt, input int snp_at,
                        input logic [31:0] snp_addr);
    bit i_seen = 0;
    bit done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      idle_inputs();
      is_halt_MEM = hlt;
      ihit = (c == ihit_at);
      snoop_inv = (c == snp_at);
      snoop_addr = snp_addr;
      if (ihit) i_seen = 1;
      #1;
      check("alu_pc", pipeline_ctrl, i_seen);
      check("alu_ren", dmemREN, 0);
      check("alu_wen", dmemWEN, 0);
      check("alu_halt", halt, 0);
      if (snoop_inv && m_match(snp_addr)) m_rv = 0;
      if (i_seen) done = 1;
    end
    check("alu_timeout", done, 1);
  endtask

  // One memory instruction: phase 0 = issue cycle, 1 = bus access, 2 = waiting to advance.
  task automatic do_mem(input bit rd, input bit wr, input bit at, input logic [31:0] addr,
                        input int acc_n, input int ihit_at, input logic [31:0] ldata,
                        input bit hlt, input int snp_at, input logic [31:0] snp_addr);
    bit is_sc = at && wr;
    bit is_lr = at && rd;
    bit fail;
    bit i_seen = 0;
    bit done = 0;
    bit exp_pc;
    bit st_match;
    int ph = 0;
    int acc_left = acc_n;
    fail = is_sc && !m_match(addr);
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge CLK);
      idle_inputs();
      MemRead_MEM = rd; MemWr_MEM = wr; datomic_MEM = at;
      alu_out_MEM = addr; is_halt_MEM = hlt;
      ihit = (c == ihit_at);
      dhit = (ph == 1 && acc_left == 1);
      dmemload = dhit ? ldata : $urandom;
      snoop_inv = (c == snp_at);
      snoop_addr = snp_addr;
      if (ihit) i_seen = 1;
      #1;
      exp_pc = (ph == 2) && i_seen;
      check("mem_ren", dmemREN, (ph == 1) && rd);
      check("mem_wen", dmemWEN, (ph == 1) && wr);
      check("mem_pc", pipeline_ctrl, exp_pc);
      check("mem_addr", dmemaddr, addr);
      check("mem_halt", halt, 0);
      if (ph == 2) check("mem_result", dmem_out_reg, m_res);
      // Model the edge: snoop first, then the transaction's own effect.
      st_match = m_match(addr);
      if (snoop_inv && m_match(snp_addr)) m_rv = 0;
      case (ph)
        0: begin
          if (fail) begin m_res = 32'd1; m_rv = 0; ph = 2; end
          else ph = 1;
        end
        1: begin
          if (dhit) begin
            if (rd) m_res = ldata;
            if (is_sc) begin m_res = 0; m_rv = 0; end
            if (is_lr) begin m_rv = 1; m_ra = addr; end
            if (wr && !at && st_match) m_rv = 0;
            ph = 2;
          end else begin
            acc_left--;
          end
        end
        default: if (exp_pc) done = 1;
      endcase
    end
    check("mem_timeout", done, 1);
  endtask

  task automatic check_halted(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge CLK);
      idle_inputs();
      ihit = 1'($urandom); dhit = 1'($urandom);
      MemRead_MEM = 1'($urandom); MemWr_MEM = 1'($urandom);
      #1;
      check("halted_halt", halt, 1);
      check("halted_pc", pipeline_ctrl, 0);
      check("halted_ren", dmemREN, 0);
      check("halted_wen", dmemWEN, 0);
    end
  endtask

  logic [31:0] bases [3] = '{32'h700, 32'h704, 32'h708};

  initial begin
    idle_inputs();
    RST = 1;
    do_reset();

    // Plain op advances in the ihit cycle.
    do_alu(0, 0, -1, '0);

    // Load: 3 access cycles, ihit arrives two cycles into DONE.
    do_mem(1, 0, 0, 32'h100, 3, 6, 32'hDEADBEEF, 0, -1, '0);
    // Load with ihit before dhit: i_done holds it until DONE.
    do_mem(1, 0, 0, 32'h104, 2, 0, 32'h12345678, 0, -1, '0);

    // LR/SC pair succeeds at word granularity, second SC fails.
    do_mem(1, 0, 1, 32'h200, 2, 1, 32'hAAAA0000, 0, -1, '0);
    do_mem(0, 1, 1, 32'h202, 1, 0, '0, 0, -1, '0);
    do_mem(0, 1, 1, 32'h200, 1, 0, '0, 0, -1, '0);

    // Matching snoop kills the reservation; a neighbouring word does not.
    do_mem(1, 0, 1, 32'h300, 1, 4, 32'h1, 0, 3, 32'h300);
    do_mem(0, 1, 1, 32'h300, 1, 0, '0, 0, -1, '0);
    do_mem(1, 0, 1, 32'h300, 1, 4, 32'h2, 0, 3, 32'h304);
    do_mem(0, 1, 1, 32'h300, 1, 0, '0, 0, -1, '0);

    // Snoop in the same cycle as LR completion: LR wins.
    do_mem(1, 0, 1, 32'h400, 2, 0, 32'h3, 0, -1, '0);
    do_mem(1, 0, 1, 32'h400, 2, 0, 32'h4, 0, 2, 32'h400);
    do_mem(0, 1, 1, 32'h400, 1, 0, '0, 0, -1, '0);

    // Snoop while SC is on the bus: SC still succeeds.
    do_mem(1, 0, 1, 32'h500, 1, 0, 32'h5, 0, -1, '0);
    do_mem(0, 1, 1, 32'h500, 3, 0, '0, 0, 2, 32'h500);

    // Plain store to the reserved word clears the reservation.
    do_mem(1, 0, 1, 32'h600, 1, 0, 32'h6, 0, -1, '0);
    do_mem(0, 1, 0, 32'h601, 1, 0, '0, 0, -1, '0);
    do_mem(0, 1, 1, 32'h600, 1, 0, '0, 0, -1, '0);

    // Randomized instruction stream against the model.
    for (int t = 0; t < 60; t++) begin
      int kind;
      logic [31:0] a, sa;
      int snp;
      kind = $urandom_range(0, 4);
      a  = bases[$urandom_range(0, 2)] | 32'($urandom_range(0, 3));
      sa = bases[$urandom_range(0, 2)];
      snp = ($urandom_range(0, 2) == 0) ? $urandom_range(0, 6) : -1;
      case (kind)
        0: do_alu($urandom_range(0, 3), 0, snp, sa);
        1: do_mem(1, 0, 0, a, $urandom_range(1, 4), $urandom_range(0, 7), $urandom, 0, snp, sa);
        2: do_mem(0, 1, 0, a, $urandom_range(1, 4), $urandom_range(0, 7), '0, 0, snp, sa);
        3: do_mem(1, 0, 1, a, $urandom_range(1, 4), $urandom_range(0, 7), $urandom, 0, snp, sa);
        default: do_mem(0, 1, 1, a, $urandom_range(1, 4), $urandom_range(0, 7), '0, 0, snp, sa);
      endcase
    end

    // Reset in the middle of an access drops the request and the reservation.
    do_mem(1, 0, 1, 32'h800, 1, 0, 32'h8, 0, -1, '0);
    @(negedge CLK);
    idle_inputs(); MemRead_MEM = 1; alu_out_MEM = 32'h900;
    #1;
    check("mid_idle_ren", dmemREN, 0);
    @(negedge CLK);
    RST = 1;
    #1;
    check("mid_access_ren", dmemREN, 1);
    @(negedge CLK);
    RST = 0;
    idle_inputs(); ihit = 1;
    m_rv = 0; m_res = '0;
    #1;
    check("post_rst_ren", dmemREN, 0);
    check("post_rst_pc", pipeline_ctrl, 1);
    check("post_rst_out", dmem_out_reg, 0);
    do_mem(0, 1, 1, 32'h800, 1, 0, '0, 0, -1, '0);

    // Halt from a plain op, then halt following a load.
    do_alu(2, 1, -1, '0);
    check_halted(6);
    do_reset();
    do_mem(1, 0, 0, 32'hA00, 2, 1, 32'hCAFEF00D, 1, -1, '0);
    check_halted(4);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
